// File: rtl/wisc_mem_pkg.sv
// Shared definitions for the cache-fill / write-through memory arbiter.
// Holds the arbiter state encoding, block geometry and the fill address helper.
package wisc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_FILL = 2'd1,
        ST_D_FILL = 2'd2,
        ST_STORE  = 2'd3
    } arb_state_t;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int MEM_LATENCY     = 4;
    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;
    localparam int WORD_IDX_W      = 3;
    localparam int BLOCK_BASE_W    = ADDR_W - WORD_IDX_W - 1;

    // Byte address of word idx of the block at base (16-bit words, byte addressed).
    function automatic logic [ADDR_W-1:0] block_word_addr(
        input logic [BLOCK_BASE_W-1:0] base,
        input logic [WORD_IDX_W-1:0]   idx
    );
        return {base, idx, 1'b0};
    endfunction

endpackage

// File: rtl/word_counter.sv
// 3-bit word index counter with synchronous clear and enable; wraps 7 -> 0.
module word_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [2:0] count
);

    // Count register: clear wins over enable, natural wrap at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 3'd0;
        end else if (clr) begin
            count <= 3'd0;
        end else if (en) begin
            count <= count + 3'd1;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and write-through stores onto one
// pipelined main-memory port; fixed priority store > D miss > I miss.
module mem_arbiter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    input  logic [15:0] mem_data_in,
    input  logic        mem_data_valid,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_out,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        i_fill_we,
    output logic        d_fill_we,
    output logic        i_fill_done,
    output logic        d_fill_done,
    output logic        d_wr_ack,
    output logic        busy
);

    import wisc_mem_pkg::*;

    localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(WORDS_PER_BLOCK - 1);

    arb_state_t                state_r;
    arb_state_t                next_s;
    logic [BLOCK_BASE_W-1:0]   base_r;
    logic                      issue_done_r;
    logic [WORD_IDX_W-1:0]     issue_cnt_s;
    logic [WORD_IDX_W-1:0]     recv_cnt_s;
    logic                      fill_active_s;
    logic                      fill_last_s;
    logic                      cnt_clr_s;
    logic                      issue_en_s;
    logic                      recv_en_s;
    logic                      unused_s;

    // Byte-in-block bits never reach memory; the return latency is absorbed by recv_cnt.
    assign unused_s = ^{i_miss_addr[3:0], d_miss_addr[3:0], 32'(MEM_LATENCY)};

    assign fill_active_s = (state_r == ST_I_FILL) || (state_r == ST_D_FILL);
    assign fill_last_s   = fill_active_s && mem_data_valid && (recv_cnt_s == LAST_IDX);
    assign cnt_clr_s     = (state_r == ST_IDLE);
    assign issue_en_s    = fill_active_s && !issue_done_r;
    assign recv_en_s     = fill_active_s && mem_data_valid;

    word_counter u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr_s),
        .en    (issue_en_s),
        .count (issue_cnt_s)
    );

    word_counter u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr_s),
        .en    (recv_en_s),
        .count (recv_cnt_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Block base latched only on the IDLE->FILL edge so later address changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_r <= '0;
        end else if ((state_r == ST_IDLE) && (next_s == ST_D_FILL)) begin
            base_r <= d_miss_addr[15:4];
        end else if ((state_r == ST_IDLE) && (next_s == ST_I_FILL)) begin
            base_r <= i_miss_addr[15:4];
        end else begin
            base_r <= base_r;
        end
    end

    // Marks that all block reads are issued, since issue_cnt itself wraps back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_done_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            issue_done_r <= 1'b0;
        end else if (issue_en_s && (issue_cnt_s == LAST_IDX)) begin
            issue_done_r <= 1'b1;
        end else begin
            issue_done_r <= issue_done_r;
        end
    end

    // Next-state: arbitration happens only in IDLE; fills end on their last return.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (d_wr_req) begin
                    next_s = ST_STORE;
                end else if (d_miss) begin
                    next_s = ST_D_FILL;
                end else if (i_miss) begin
                    next_s = ST_I_FILL;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_I_FILL, ST_D_FILL: begin
                if (fill_last_s) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = state_r;
                end
            end
            ST_STORE: next_s = ST_IDLE;
            default:  next_s = ST_IDLE;
        endcase
    end

    // Output decode from state; everything is zero in IDLE so reset clears outputs at once.
    always_comb begin
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'h0000;
        mem_data_out = 16'h0000;
        fill_data    = 16'h0000;
        fill_word    = 3'd0;
        i_fill_we    = 1'b0;
        d_fill_we    = 1'b0;
        i_fill_done  = 1'b0;
        d_fill_done  = 1'b0;
        d_wr_ack     = 1'b0;
        busy         = (state_r != ST_IDLE);
        case (state_r)
            ST_I_FILL, ST_D_FILL: begin
                mem_en    = !issue_done_r;
                fill_word = recv_cnt_s;
                if (!issue_done_r) begin
                    mem_addr = block_word_addr(base_r, issue_cnt_s);
                end else begin
                    mem_addr = 16'h0000;
                end
                if (mem_data_valid) begin
                    fill_data = mem_data_in;
                end else begin
                    fill_data = 16'h0000;
                end
                if (state_r == ST_I_FILL) begin
                    i_fill_we   = mem_data_valid;
                    i_fill_done = fill_last_s;
                end else begin
                    d_fill_we   = mem_data_valid;
                    d_fill_done = fill_last_s;
                end
            end
            ST_STORE: begin
                mem_en       = 1'b1;
                mem_wr       = 1'b1;
                mem_addr     = d_wr_addr;
                mem_data_out = d_wr_data;
                d_wr_ack     = 1'b1;
            end
            default: begin
                busy = (state_r != ST_IDLE);
            end
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001: Parameter WORDS_PER_BLOCK, 8, number of 16-bit words in one cache block fill.
REQ-002: Parameter MEM_LATENCY, 4, cycles from a mem_en read issue to its mem_data_valid return (pipelined memory).
REQ-003: clk  in  1  single clock; all state updates on rising edge.
REQ-004: rst  in  1  reset, asynchronous, active-high.
REQ-005: i_miss  in  1  instruction-cache miss, level, held until i_fill_done.
REQ-006: i_miss_addr  in  16  byte address of the instruction-cache miss.
REQ-007: d_miss  in  1  data-cache read miss, level, held until d_fill_done.
REQ-008: d_miss_addr  in  16  byte address of the data-cache miss.
REQ-009: d_wr_req  in  1  write-through store request, level, held until d_wr_ack.
REQ-010: d_wr_addr / d_wr_data  in  16 / 16  store address and data.
REQ-011: mem_data_in  in  16  read data from main memory.
REQ-012: mem_data_valid  in  1  mem_data_in carries the return for the read issued MEM_LATENCY cycles earlier.
REQ-013: mem_en / mem_wr  out  1 / 1  memory access strobe; write qualifier.
REQ-014: mem_addr / mem_data_out  out  16 / 16  memory address; store data.
REQ-015: fill_data / fill_word  out  16 / 3  returning word and its index within the block.
REQ-016: i_fill_we / d_fill_we  out  1 / 1  write fill_data into the I- or D-cache data array at fill_word.
REQ-017: i_fill_done / d_fill_done / d_wr_ack  out  1 / 1 / 1  one-cycle completion pulses.
REQ-018: busy  out  1  high in every state except IDLE.

Function
REQ-019: FSM states IDLE, I_FILL, D_FILL, STORE; transitions out of IDLE only, evaluated on the IDLE cycle.
REQ-020: Fixed priority in IDLE: d_wr_req > d_miss > i_miss; losers wait with requests held, no starvation guarantee required.
REQ-021: Block base = miss_addr[15:4] captured on the IDLE->FILL edge; later address changes ignored.
REQ-022: FILL issue: mem_en=1, mem_wr=0 for WORDS_PER_BLOCK consecutive cycles starting the first FILL cycle; mem_addr = {base, issue_cnt, 1'b0}, issue_cnt 0..7.
REQ-023: FILL receive: each mem_data_valid advances recv_cnt; fill_word = recv_cnt; fill_data = mem_data_in; matching *_fill_we = mem_data_valid.
REQ-024: *_fill_done pulses on the cycle the 8th valid word is accepted; FSM returns to IDLE the next cycle.
REQ-025: Timing: request seen in IDLE at cycle N -> mem_en N+1..N+8, valid/we N+5..N+12, done N+12, IDLE N+13.
REQ-026: STORE: one cycle with mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_out=d_wr_data, d_wr_ack=1; IDLE next cycle.
REQ-027: mem_data_valid outside I_FILL/D_FILL is ignored; no *_fill_we asserted.
REQ-028: issue_cnt and recv_cnt wrap 7->0 and clear on entry to a FILL state; mem_en stays low after issue_cnt completes.
REQ-029: Requesters deassert the completed request no later than the cycle after done/ack; a request still high in IDLE starts a new transaction.
REQ-030: mem_data_out = 0 and mem_addr = 0 whenever mem_en = 0.

Reset
REQ-031: rst asserted at any time forces IDLE, counters 0, base 0, all outputs 0 immediately, no done/ack pulse for the aborted transaction.
REQ-032: Main memory shares rst; no in-flight returns survive reset.

Structure
REQ-033: Shared package wisc_mem_pkg holds the state enum, WORDS_PER_BLOCK, MEM_LATENCY and block/word field widths.
REQ-034: One sub-module word_counter (3-bit, clear/enable/wrap), instantiated for issue_cnt and recv_cnt.

Verification
REQ-035: i_miss=1, addr 0x1236 -> mem_addr 0x1230..0x123E on 8 cycles, i_fill_we with fill_word 0..7, i_fill_done at N+12.
REQ-036: i_miss and d_miss same cycle (0x0040, 0x8008) -> D fill of 0x8000 block first, I fill of 0x0040 block starts cycle after d_fill_done+IDLE.
REQ-037: d_wr_req addr 0x2002 data 0xBEEF with d_miss pending -> one STORE cycle (mem_wr=1, 0xBEEF), d_wr_ack, then D fill.
REQ-038: Spurious mem_data_valid in IDLE -> no fill_we, no state change.
REQ-039: rst asserted at cycle N+7 of a fill -> outputs 0 same cycle, IDLE after release, no done pulse; re-request completes normally.
REQ-040: Back-to-back i_miss held one cycle past done -> second full fill of same block (requester violation visible), checker flags it.
